ip_header_encode8: RTL

//  Transmit-side counterpart of the IP section decoder on the UDP/IP RX path.
//  - Latches the IPv4 header fields on a start pulse.
//  - Computes the header checksum sequentially.
//  - Serialises the 20-byte IPv4 header (no options) MSB-first, one byte per

---
 rtl/ip_header_encode8.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ip_header_encode8.sv
// IPv4 header transmitter: latches header fields on start, computes the header
// checksum over ten cycles, then streams the 20 header bytes MSB-first.
module ip_header_encode8 #(
   parameter int         AVL_SIZE  = 8,
   parameter int         IP_SIZE   = 32,
   parameter int         HDR_BYTES = 20,
   parameter logic [7:0] TTL       = 8'h40
) (
   input  logic                clk_i,
   input  logic                sync_reset_i,
   input  logic                start_i,
   input  logic [IP_SIZE-1:0]  src_ip_i,
   input  logic [IP_SIZE-1:0]  dst_ip_i,
   input  logic [15:0]         payload_len_i,
   input  logic [7:0]          protocol_i,
   input  logic [15:0]         ident_i,
   output logic                busy_o,
   output logic [AVL_SIZE-1:0] data_out_o,
   output logic                data_out_valid_o,
   output logic                data_out_last_o,
   input  logic                data_out_ready_i
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SUM  = 2'd1;
   localparam logic [1:0] ST_FOLD = 2'd2;
   localparam logic [1:0] ST_SEND = 2'd3;

   localparam logic [4:0] LAST_IDX  = 5'(HDR_BYTES - 1);
   localparam logic [3:0] LAST_WORD = 4'(HDR_BYTES / 2 - 1);
   localparam logic [3:0] CSUM_WORD = 4'd5;

   logic [1:0]         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [4:0]         idx_q, idx_d;
   logic [19:0]        acc_q, acc_d;
   logic [15:0]        csum_q, csum_d;
   logic [IP_SIZE-1:0] src_q, src_d;
   logic [IP_SIZE-1:0] dst_q, dst_d;
   logic [15:0]        len_q, len_d;
   logic [7:0]         proto_q, proto_d;
   logic [15:0]        ident_q, ident_d;

   logic [15:0] hdr_w [10];
   logic [15:0] sum_w;
   logic [15:0] send_w;
   logic [7:0]  send_byte;
   logic [16:0] fold_s;

   always_comb begin
      hdr_w[0] = 16'h4500;
      hdr_w[1] = len_q + 16'(HDR_BYTES);
      hdr_w[2] = ident_q;
      hdr_w[3] = 16'h4000;
      hdr_w[4] = {TTL, proto_q};
      hdr_w[5] = csum_q;
      hdr_w[6] = src_q[31:16];
      hdr_w[7] = src_q[15:0];
      hdr_w[8] = dst_q[31:16];
      hdr_w[9] = dst_q[15:0];
   end

   // The checksum word contributes zero while the sum is being formed.
   assign sum_w     = (cnt_q == CSUM_WORD) ? 16'h0000 : hdr_w[cnt_q];
   assign send_w    = hdr_w[idx_q[4:1]];
   assign send_byte = idx_q[0] ? send_w[7:0] : send_w[15:8];
   assign fold_s    = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};

   assign busy_o           = (state_q != ST_IDLE);
   assign data_out_valid_o = (state_q == ST_SEND);
   assign data_out_last_o  = data_out_valid_o && (idx_q == LAST_IDX);
   assign data_out_o       = data_out_valid_o ? AVL_SIZE'(send_byte) : '0;

   always_comb begin
      // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      csum_d  = csum_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      proto_d = proto_q;
      ident_d = ident_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               src_d   = src_ip_i;
               dst_d   = dst_ip_i;
               len_d   = payload_len_i;
               proto_d = protocol_i;
               ident_d = ident_i;
               acc_d   = '0;
               csum_d  = '0;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = ST_SUM;
            end
         end
         ST_SUM: begin
            acc_d = acc_q + 20'(sum_w);
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_WORD) state_d = ST_FOLD;
         end
         ST_FOLD: begin
            csum_d  = ~(fold_s[15:0] + {15'b0, fold_s[16]});
            state_d = ST_SEND;
         end
         default: begin
            if (data_out_ready_i) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the reset clears every register, fields included.
   always_ff @(posedge clk_i) begin
      if (sync_reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         csum_q  <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         proto_q <= '0;
         ident_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         csum_q  <= csum_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         proto_q <= proto_d;
         ident_q <= ident_d;
      end
   end

endmodule
